// File: rtl/mips_ctl_pkg.sv
// Shared state encoding, opcode and datapath select constants for the multicycle MIPS control.
// MCCTL_BNE_EN adds the S_BNE_EX state used for bne support.
package mips_ctl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
`ifdef MCCTL_BNE_EN
    S_BNE_EX   = 4'd13,
`endif
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_SEXT    = 2'b10;
  localparam logic [1:0] ALUB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctl_opdecode.sv
// Opcode dispatch for the decode state: selects the execute state and flags unknown opcodes.
// bne (0x05) is only recognised when MCCTL_BNE_EN is defined.
module mips_ctl_opdecode
  import mips_ctl_pkg::*;
(
  input  logic [5:0] opcode,
  output state_t     next_state,
  output logic       illegal
);

  always_comb begin
    next_state = S_FETCH;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE:     next_state = S_RTYPE_EX;
      OP_LW, OP_SW: next_state = S_MEMADR;
      OP_BEQ:       next_state = S_BEQ_EX;
`ifdef MCCTL_BNE_EN
      OP_BNE:       next_state = S_BNE_EX;
`endif
      OP_ADDI:      next_state = S_ADDI_EX;
      OP_J:         next_state = S_JUMP;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctl.sv
// Main control FSM for the multicycle MIPS datapath; outputs are decoded from the current state.
// Define MCCTL_BNE_EN to add bne support (S_BNE_EX, branch_ne output).
module mips_multicycle_ctl
  import mips_ctl_pkg::*;
#(
  parameter int unsigned RESET_IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       branch_ne,
  output logic       illegal_op
);

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  state_t     dec_next;
  logic       dec_illegal;
  logic       unused_zero;

  // The branch condition itself is evaluated in the datapath (pcwritecond & zero).
  assign unused_zero = zero;

  mips_ctl_opdecode u_opdecode (
    .opcode     (opcode),
    .next_state (dec_next),
    .illegal    (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUB_RT;
    pcsrc       = PCSRC_ALU;
    aluop       = ALUOP_ADD;
    branch_ne   = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == IDLE_LAST) state_d = S_FETCH;
        else idle_cnt_d = idle_cnt_q + 4'd1;
      end
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = ALUB_FOUR;
        // IR and PC load together only on the cycle memory delivers the word.
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb    = ALUB_SEXT_SH;
        illegal_op = dec_illegal;
        state_d    = dec_next;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUB_SEXT;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ_EX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        pcwritecond = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef MCCTL_BNE_EN
      S_BNE_EX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        pcwritecond = 1'b1;
        branch_ne   = 1'b1;
        state_d     = S_FETCH;
      end
`endif
      S_ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = ALUB_SEXT;
        aluop   = ALUOP_ADDI;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctl.sv
// Scoreboard bench for mips_multicycle_ctl: stimulus queues the expected control word per cycle,
// a monitor pops and compares. Expectations follow MCCTL_BNE_EN for the 0x05 opcode.
module tb_mips_multicycle_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;
  logic       zero = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, branch_ne, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;

  mips_multicycle_ctl #(.RESET_IDLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .aluop(aluop), .branch_ne(branch_ne), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Word layout: pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst regwrite alusrca
  //              | alusrcb | pcsrc | aluop | branch_ne illegal_op
  logic [17:0] act;
  assign act = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                regwrite, alusrca, alusrcb, pcsrc, aluop, branch_ne, illegal_op};

  localparam logic [17:0] E_IDLE   = 18'd0;
  localparam logic [17:0] E_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_RTEX   = {10'b0000000001, 2'b00, 2'b00, 2'b10, 2'b00};
  localparam logic [17:0] E_RTWB   = {10'b0000000110, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_BEQ    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam logic [17:0] E_BNE    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [17:0] E_ADDIEX = {10'b0000000001, 2'b10, 2'b00, 2'b11, 2'b00};
  localparam logic [17:0] E_ADDIWB = {10'b0000000010, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_JUMP   = {10'b1000000000, 2'b00, 2'b10, 2'b00, 2'b00};

  function automatic logic [17:0] e_fetch(input logic mr);
    return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  endfunction

  function automatic logic [17:0] e_decode(input logic ill);
    return {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, ill};
  endfunction

  typedef struct {
    logic [17:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  event smp_ev;

  // Monitor: one comparison per queued expectation, on the falling edge or on demand.
  always @(negedge clk or smp_ev) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (act !== x.exp) begin
        failures++;
        $display("FAIL %s got=%05h exp=%05h", x.name, act, x.exp);
      end
    end
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic cyc(input logic rn, input logic mr, input logic [5:0] op,
                     input logic [17:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n     = rn;
    mem_ready = mr;
    opcode    = op;
    x.exp  = e;
    x.name = nm;
    q.push_back(x);
    $display("cycle t=%0t %s rst_n=%0b mem_ready=%0b opcode=%02h exp=%05h", $time, nm, rn, mr, op, e);
  endtask

  // Fetch then decode with mem_ready high, common to every instruction.
  task automatic fetch_decode(input logic [5:0] op, input logic ill, input string nm);
    cyc(1'b1, 1'b1, op, e_fetch(1'b1), {nm, "_fetch"});
    cyc(1'b1, 1'b1, op, e_decode(ill), {nm, "_decode"});
  endtask

  initial begin
    exp_t x;
    bit   seen_memwrite;
    cyc(1'b0, 1'b1, 6'h23, E_IDLE, "in_reset0");
    @(negedge clk);
    #1;
    checks++;
    if (act !== E_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%05h exp=%05h", act, E_IDLE);
    end else begin
      $display("reset_state t=%0t got=%05h", $time, act);
    end
    cyc(1'b0, 1'b1, 6'h23, E_IDLE, "in_reset1");
    cyc(1'b1, 1'b1, 6'h23, E_IDLE, "idle_after_release");

    // lw with three wait cycles in both fetch and memory read
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 6'h23, e_fetch(1'b0), "lw_fetch_stall");
    cyc(1'b1, 1'b1, 6'h23, e_fetch(1'b1), "lw_fetch_ready");
    cyc(1'b1, 1'b1, 6'h23, e_decode(1'b0), "lw_decode");
    cyc(1'b1, 1'b1, 6'h23, E_MEMADR, "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 6'h23, E_MEMRD, "lw_memrd_stall");
    cyc(1'b1, 1'b1, 6'h23, E_MEMRD, "lw_memrd_ready");
    cyc(1'b1, 1'b1, 6'h23, E_MEMWB, "lw_memwb");

    fetch_decode(6'h00, 1'b0, "rtype");
    cyc(1'b1, 1'b1, 6'h00, E_RTEX, "rtype_ex");
    cyc(1'b1, 1'b1, 6'h00, E_RTWB, "rtype_wb");

    fetch_decode(6'h04, 1'b0, "beq");
    cyc(1'b1, 1'b1, 6'h04, E_BEQ, "beq_ex");

`ifdef MCCTL_BNE_EN
    fetch_decode(6'h05, 1'b0, "bne");
    cyc(1'b1, 1'b1, 6'h05, E_BNE, "bne_ex");
`else
    fetch_decode(6'h05, 1'b1, "op05_illegal");
`endif

    fetch_decode(6'h3F, 1'b1, "op3f_illegal");

    fetch_decode(6'h08, 1'b0, "addi");
    cyc(1'b1, 1'b1, 6'h08, E_ADDIEX, "addi_ex");
    cyc(1'b1, 1'b1, 6'h08, E_ADDIWB, "addi_wb");

    fetch_decode(6'h02, 1'b0, "jump");
    cyc(1'b1, 1'b1, 6'h02, E_JUMP, "jump_ex");

    // sw stalled in memory write, then aborted by reset mid-cycle
    fetch_decode(6'h2B, 1'b0, "sw");
    cyc(1'b1, 1'b1, 6'h2B, E_MEMADR, "sw_memadr");
    seen_memwrite = 1'b0;
    fork
      begin
        for (int i = 0; i < 4 && !seen_memwrite; i++) begin
          @(negedge clk);
          if (memwrite === 1'b1) seen_memwrite = 1'b1;
        end
        checks++;
        if (!seen_memwrite) begin
          failures++;
          $display("FAIL sw_memwrite_wait expired t=%0t", $time);
        end else begin
          $display("sw_memwrite_wait t=%0t memwrite seen", $time);
        end
      end
    join_none
    cyc(1'b1, 1'b0, 6'h2B, E_MEMWR, "sw_memwr_stall0");
    cyc(1'b1, 1'b0, 6'h2B, E_MEMWR, "sw_memwr_stall1");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    x.exp  = E_IDLE;
    x.name = "async_reset_abort";
    q.push_back(x);
    $display("async reset t=%0t exp=%05h", $time, E_IDLE);
    -> smp_ev;
    cyc(1'b0, 1'b0, 6'h2B, E_IDLE, "reset_hold");
    cyc(1'b1, 1'b1, 6'h2B, E_IDLE, "idle_restart");
    cyc(1'b1, 1'b1, 6'h2B, e_fetch(1'b1), "fetch_restart");

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctl.md
Name: mips_multicycle_ctl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over multiple clocks, and drives every datapath enable and mux select.
- Produces the 2-bit aluop consumed directly by the ALU control decoder, together with the instruction funct field.
- Sits between the instruction register (opcode in) and the datapath/ALU control (control out). It waits on a memory ready handshake.

Parameters:
- RESET_IDLE_CYCLES, 1, number of S_IDLE cycles after reset release before the first fetch (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- zero  input  1  ALU zero flag.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load if the branch condition holds.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  writeback select: 0=ALUOut, 1=MDR.
- regdst  output  1  destination register select: 0=rt, 1=rd.
- regwrite  output  1  register file write.
- alusrca  output  1  ALU A select: 0=PC, 1=rs.
- alusrcb  output  2  ALU B select: 00=rt, 01=4, 10=signext, 11=signext<<2.
- pcsrc  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- aluop  output  2  00 add, 01 sub, 10 funct, 11 add-immediate.
- branch_ne  output  1  invert zero for the branch condition.
- illegal_op  output  1  one-cycle pulse when an unknown opcode is decoded.

Behaviour:
- Reset:
  - rst_n low forces the state to S_IDLE and clears the idle counter.
  - All outputs are 0 in S_IDLE.
  - Reset asserted mid-instruction aborts that instruction immediately; no partial write follows.
- Idle: after RESET_IDLE_CYCLES cycles in S_IDLE, go to S_FETCH.
- S_FETCH:
  - Outputs: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=mem_ready and pcwrite=mem_ready, so both are qualified in the same cycle.
  - Stay while mem_ready=0; go to S_DECODE when mem_ready=1.
- S_DECODE:
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Dispatch on opcode: 0x00→S_RTYPE_EX; 0x23 or 0x2B→S_MEMADR; 0x04→S_BEQ_EX; 0x08→S_ADDI_EX; 0x02→S_JUMP.
  - Any other opcode: illegal_op=1 for this cycle only, then S_FETCH.
- S_MEMADR: alusrca=1, alusrcb=10, aluop=00. Go to S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD:
  - Outputs: memread=1, iord=1.
  - Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB: regwrite=1, memtoreg=1, regdst=0. Then S_FETCH.
- S_MEMWR:
  - Outputs: memwrite=1, iord=1.
  - Wait for mem_ready, then go to S_FETCH.
- S_RTYPE_EX: alusrca=1, alusrcb=00, aluop=10. Then S_RTYPE_WB.
- S_RTYPE_WB: regwrite=1, regdst=1, memtoreg=0. Then S_FETCH.
- S_BEQ_EX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcwritecond=1. Then S_FETCH.
- S_ADDI_EX: alusrca=1, alusrcb=10, aluop=11. Then S_ADDI_WB.
- S_ADDI_WB: regwrite=1, regdst=0, memtoreg=0. Then S_FETCH.
- S_JUMP: pcsrc=10, pcwrite=1. Then S_FETCH.
- Stalls:
  - During a stall every select output holds its value, so ALU and memory inputs stay stable.
  - memread and memwrite stay high until the mem_ready cycle.
- General rules:
  - Outputs not listed for a state are 0.
  - pcwrite and pcwritecond are never both 1.
  - memread and memwrite are never both 1.
  - The state register is the only sequential element besides the idle counter.
- Latency in cycles, with mem_ready always 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.

Optional Feature:
- MCCTL_BNE_EN defined:
  - opcode 0x05 dispatches from S_DECODE to S_BNE_EX.
  - S_BNE_EX drives the same outputs as S_BEQ_EX plus branch_ne=1.
- MCCTL_BNE_EN undefined:
  - 0x05 is an illegal opcode.
  - branch_ne is tied to 0 and S_BNE_EX does not exist.

Decomposition:
- Package mips_ctl_pkg holds:
  - 4-bit state encoding localparams;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - aluop constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_ADDI);
  - alusrcb and pcsrc select constants.
- One sub-module, mips_ctl_opdecode: combinational opcode→next-state dispatch plus the illegal flag. It is used only in S_DECODE.

Test Plan:
- Reset release with RESET_IDLE_CYCLES=1, mem_ready=1 → all outputs 0 for 1 cycle, then S_FETCH with memread=1, irwrite=1, pcwrite=1.
- lw (0x23), mem_ready low for 3 cycles in both fetch and read → fetch held 4 cycles, S_MEMRD held 4 cycles with iord=1, then regwrite=1 and memtoreg=1 for exactly one cycle.
- R-type (0x00) → aluop=10 in the exec cycle, then regwrite=1 with regdst=1; total 4 cycles.
- beq (0x04) → pcwritecond=1, aluop=01, pcsrc=01 in cycle 3. Then opcode 0x05 → illegal_op pulses 1 cycle without the macro, or branch_ne=1 with MCCTL_BNE_EN.
- Illegal opcode 0x3F → illegal_op=1 in the decode cycle only, return to S_FETCH, no regwrite/memwrite/pcwrite issued.
- rst_n asserted during S_MEMWR with mem_ready=0 → memwrite drops asynchronously to 0; after release the FSM restarts at S_IDLE.
